// File: rtl/coprosit_alu_ctrl.sv
// Coprosit ALU issue/result controller: drives the compare/min/max ALU and
// returns its results in order to the host over a valid/ready interface.

package prau_pkg;
  localparam int POSLEN = 32;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    PADD = 4'd1,
    PSUB = 4'd2,
    PMUL = 4'd3,
    PDIV = 4'd4,
    PEQ  = 4'd5,
    PLT  = 4'd6,
    PLE  = 4'd7,
    PMIN = 4'd8,
    PMAX = 4'd9
  } prau_op_e;
endpackage

module coprosit_alu_ctrl
  import prau_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int ID_WIDTH   = 4,
  parameter int RD_WIDTH   = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [POSLEN-1:0]   issue_operand_a_i,
  input  logic [POSLEN-1:0]   issue_operand_b_i,
  input  prau_op_e            issue_operator_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [RD_WIDTH-1:0] issue_rd_i,
  output logic [POSLEN-1:0]   alu_operand_a_o,
  output logic [POSLEN-1:0]   alu_operand_b_o,
  output prau_op_e            alu_operator_o,
  output logic                alu_input_hs_o,
  output logic                alu_output_hs_o,
  input  logic [XLEN-1:0]     alu_result_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [XLEN-1:0]     result_data_o,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [RD_WIDTH-1:0] result_rd_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 2;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

  logic                exec_q, exec_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [RD_WIDTH-1:0] rd_q, rd_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [XLEN-1:0]     data_mem [FIFO_DEPTH];
  logic [ID_WIDTH-1:0] id_mem   [FIFO_DEPTH];
  logic [RD_WIDTH-1:0] rd_mem   [FIFO_DEPTH];

  logic                fire, pop, push;
  logic [CNT_W-1:0]    occupancy;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    result_valid_o = (count_q != '0);
    pop            = result_valid_o & result_ready_i;
    push           = exec_q & ~flush_i;

    // Counting the in-flight op reserves its slot, so a capture can never overflow.
    occupancy      = count_q + CNT_W'(exec_q) - CNT_W'(pop);
    // rst_ni gating keeps the handshake and strobes quiet while held in reset.
    issue_ready_o  = rst_ni & ~flush_i & (occupancy < DEPTH_C);
    fire           = issue_valid_i & issue_ready_o;

    alu_input_hs_o  = fire;
    alu_output_hs_o = exec_q & ~fire;
    alu_operand_a_o = fire ? issue_operand_a_i : '0;
    alu_operand_b_o = fire ? issue_operand_b_i : '0;
    alu_operator_o  = fire ? issue_operator_i  : NONE;

    result_data_o = result_valid_o ? data_mem[rd_ptr_q] : '0;
    result_id_o   = result_valid_o ? id_mem[rd_ptr_q]   : '0;
    result_rd_o   = result_valid_o ? rd_mem[rd_ptr_q]   : '0;

    exec_d   = fire;
    id_d     = fire ? issue_id_i : id_q;
    rd_d     = fire ? issue_rd_i : rd_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exec_q   <= 1'b0;
      id_q     <= '0;
      rd_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      exec_q   <= exec_d;
      id_q     <= id_d;
      rd_q     <= rd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only observable when
  // count_q covers them, and the outputs are forced to 0 otherwise.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr_q] <= alu_result_i;
      id_mem[wr_ptr_q]   <= id_q;
      rd_mem[wr_ptr_q]   <= rd_q;
    end
  end

endmodule

// File: tb/tb_coprosit_alu_ctrl.sv
// Randomized self-checking bench for coprosit_alu_ctrl: an ALU stand-in plus a
// transaction-level model that tracks each accepted instruction by issue cycle.

module tb_coprosit_alu_ctrl;
  import prau_pkg::*;

  localparam int XLEN       = 64;
  localparam int ID_WIDTH   = 4;
  localparam int RD_WIDTH   = 5;
  localparam int FIFO_DEPTH = 2;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                flush_i = 1'b0;
  logic                issue_valid_i = 1'b0;
  logic                issue_ready_o;
  logic [POSLEN-1:0]   issue_operand_a_i = '0;
  logic [POSLEN-1:0]   issue_operand_b_i = '0;
  prau_op_e            issue_operator_i = NONE;
  logic [ID_WIDTH-1:0] issue_id_i = '0;
  logic [RD_WIDTH-1:0] issue_rd_i = '0;
  logic [POSLEN-1:0]   alu_operand_a_o;
  logic [POSLEN-1:0]   alu_operand_b_o;
  prau_op_e            alu_operator_o;
  logic                alu_input_hs_o;
  logic                alu_output_hs_o;
  logic [XLEN-1:0]     alu_result_i;
  logic                result_valid_o;
  logic                result_ready_i = 1'b0;
  logic [XLEN-1:0]     result_data_o;
  logic [ID_WIDTH-1:0] result_id_o;
  logic [RD_WIDTH-1:0] result_rd_o;

  coprosit_alu_ctrl #(
    .XLEN(XLEN), .ID_WIDTH(ID_WIDTH), .RD_WIDTH(RD_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_operand_a_i(issue_operand_a_i), .issue_operand_b_i(issue_operand_b_i),
    .issue_operator_i(issue_operator_i), .issue_id_i(issue_id_i), .issue_rd_i(issue_rd_i),
    .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
    .alu_operator_o(alu_operator_o), .alu_input_hs_o(alu_input_hs_o),
    .alu_output_hs_o(alu_output_hs_o), .alu_result_i(alu_result_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_data_o(result_data_o), .result_id_o(result_id_o), .result_rd_o(result_rd_o)
  );

  always #5 clk_i = ~clk_i;

  // Posits order like two's-complement integers; results are zero-extended.
  function automatic logic [XLEN-1:0] alu_f(prau_op_e o, logic [POSLEN-1:0] x,
                                            logic [POSLEN-1:0] y);
    logic signed [POSLEN-1:0] sx, sy;
    sx = x;
    sy = y;
    case (o)
      PEQ:     return XLEN'(x == y);
      PLT:     return XLEN'(sx < sy);
      PLE:     return XLEN'(sx <= sy);
      PMIN:    return XLEN'((sx < sy) ? x : y);
      PMAX:    return XLEN'((sx < sy) ? y : x);
      default: return '0;
    endcase
  endfunction

  // ALU stand-in: operand registers loaded on input_hs, cleared on output_hs.
  prau_op_e          alu_op_r;
  logic [POSLEN-1:0] alu_a_r, alu_b_r;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_op_r <= NONE; alu_a_r <= '0; alu_b_r <= '0;
    end else if (alu_input_hs_o) begin
      alu_op_r <= alu_operator_o; alu_a_r <= alu_operand_a_o; alu_b_r <= alu_operand_b_o;
    end else if (alu_output_hs_o) begin
      alu_op_r <= NONE; alu_a_r <= '0; alu_b_r <= '0;
    end
  end
  always_comb alu_result_i = alu_f(alu_op_r, alu_a_r, alu_b_r);

  typedef struct {
    logic [XLEN-1:0]     data;
    logic [ID_WIDTH-1:0] id;
    logic [RD_WIDTH-1:0] rd;
    int                  t;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   tog = 1'b0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: check every output against the model at the negedge, then
  // update the model at the posedge. An instruction accepted in cycle t is
  // visible at the head from cycle t+2 on.
  task automatic step(output bit fired);
    int  n_prior;
    bit  exp_valid, exp_ready, pop_e, fire_e, inflight;
    if (tog) result_ready_i = cyc[0];
    @(negedge clk_i);
    n_prior  = 0;
    inflight = 1'b0;
    foreach (q[i]) begin
      if (q[i].t < cyc) n_prior++;
      if (q[i].t == cyc - 1) inflight = 1'b1;
    end
    exp_valid = (q.size() > 0) && (q[0].t + 2 <= cyc);
    check("valid", result_valid_o, exp_valid);
    if (exp_valid) begin
      check("data", result_data_o, q[0].data);
      check("id", result_id_o, q[0].id);
      check("rd", result_rd_o, q[0].rd);
    end
    pop_e     = exp_valid && result_ready_i;
    exp_ready = !flush_i && ((n_prior - int'(pop_e)) < FIFO_DEPTH);
    check("ready", issue_ready_o, exp_ready);
    fire_e = issue_valid_i && exp_ready;
    check("in_hs", alu_input_hs_o, fire_e);
    check("out_hs", alu_output_hs_o, inflight && !fire_e);
    check("opa", alu_operand_a_o, fire_e ? issue_operand_a_i : '0);
    check("opb", alu_operand_b_o, fire_e ? issue_operand_b_i : '0);
    check("oper", 64'(alu_operator_o), fire_e ? 64'(issue_operator_i) : 64'(NONE));
    @(posedge clk_i);
    if (pop_e) void'(q.pop_front());
    if (flush_i) q.delete();
    if (fire_e)
      q.push_back('{alu_f(issue_operator_i, issue_operand_a_i, issue_operand_b_i),
                    issue_id_i, issue_rd_i, cyc});
    cyc++;
    fired = fire_e;
    #1;
  endtask

  task automatic issue(prau_op_e o, logic [POSLEN-1:0] x, logic [POSLEN-1:0] y,
                       logic [ID_WIDTH-1:0] id, logic [RD_WIDTH-1:0] rd);
    bit f = 1'b0;
    issue_valid_i = 1'b1; issue_operator_i = o;
    issue_operand_a_i = x; issue_operand_b_i = y;
    issue_id_i = id; issue_rd_i = rd;
    for (int k = 0; k < 20; k++) begin
      step(f);
      if (f) return;
    end
    check("issue_timeout", f, 1);
  endtask

  task automatic idle(int n);
    bit f;
    issue_valid_i = 1'b0;
    for (int k = 0; k < n; k++) step(f);
  endtask

  task automatic check_all_zero();
    check("rst_ready", issue_ready_o, 0);
    check("rst_valid", result_valid_o, 0);
    check("rst_in_hs", alu_input_hs_o, 0);
    check("rst_out_hs", alu_output_hs_o, 0);
    check("rst_opa", alu_operand_a_o, 0);
    check("rst_opb", alu_operand_b_o, 0);
    check("rst_oper", 64'(alu_operator_o), 64'(NONE));
    check("rst_data", result_data_o, 0);
    check("rst_id", result_id_o, 0);
    check("rst_rd", result_rd_o, 0);
  endtask

  initial begin
    bit f;
    issue_valid_i = 1'b1;
    issue_operator_i = PEQ;
    @(negedge clk_i);
    check_all_zero();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Single PLT: result 0, id 3, rd 7, two cycles after issue.
    result_ready_i = 1'b1;
    issue(PLT, 32'h4000_0000, 32'hC000_0000, 4'd3, 5'd7);
    idle(3);

    // Back-to-back PMAX then PMIN.
    issue(PMAX, 32'h4000_0000, 32'hC000_0000, 4'd1, 5'd1);
    issue(PMIN, 32'h4000_0000, 32'hC000_0000, 4'd2, 5'd2);
    idle(4);

    // Host stalled: two PEQ accepted, third refused until ready returns.
    result_ready_i = 1'b0;
    issue(PEQ, 32'h1, 32'h1, 4'd4, 5'd4);
    issue(PEQ, 32'h1, 32'h1, 4'd5, 5'd5);
    step(f);
    check("third_refused", f, 0);
    step(f);
    result_ready_i = 1'b1;
    issue(PEQ, 32'h1, 32'h1, 4'd6, 5'd6);
    idle(5);

    // FIFO wrap with ready toggling every cycle.
    tog = 1'b1;
    for (int k = 0; k < 5; k++)
      issue(PLE, $urandom, $urandom, ID_WIDTH'(k + 8), RD_WIDTH'(k));
    idle(8);
    tog = 1'b0;
    result_ready_i = 1'b1;
    idle(2);

    // Flush the cycle after an issue, with one entry already buffered.
    result_ready_i = 1'b0;
    issue(PMAX, 32'h7, 32'h3, 4'd10, 5'd10);
    idle(2);
    issue(PMIN, 32'h7, 32'h3, 4'd11, 5'd11);
    issue_valid_i = 1'b0;
    flush_i = 1'b1;
    step(f);
    flush_i = 1'b0;
    idle(1);
    result_ready_i = 1'b1;
    issue(PLT, 32'hFFFF_FFFF, 32'h1, 4'd12, 5'd12);
    idle(3);

    // Asynchronous reset with an op in flight and one entry buffered.
    result_ready_i = 1'b0;
    issue(PEQ, 32'h5, 32'h5, 4'd13, 5'd13);
    issue(PEQ, 32'h5, 32'h6, 4'd14, 5'd14);
    issue_operator_i = PMAX;
    rst_ni = 1'b0;
    #1;
    check_all_zero();
    q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    result_ready_i = 1'b1;
    issue(PMAX, 32'h8000_0001, 32'h0000_0002, 4'd15, 5'd15);
    idle(3);

    // Random traffic, including non-ALU operators and occasional flushes.
    for (int k = 0; k < 3000; k++) begin
      issue_valid_i     = ($urandom_range(0, 3) != 0);
      result_ready_i    = ($urandom_range(0, 2) != 0);
      flush_i           = ($urandom_range(0, 31) == 0);
      issue_operator_i  = prau_op_e'($urandom_range(0, 9));
      issue_operand_a_i = $urandom;
      issue_operand_b_i = ($urandom_range(0, 3) == 0) ? issue_operand_a_i : $urandom;
      issue_id_i        = ID_WIDTH'($urandom);
      issue_rd_i        = RD_WIDTH'($urandom);
      step(f);
    end
    flush_i = 1'b0;
    result_ready_i = 1'b1;
    idle(5);
    check("drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
